stream_demux2: RTL and testbench
================================

STREAM_DEMUX2 -- requirements
Module: stream_demux2

Interface
REQ-001 Parameter WIDTH, default 64: data word width in bits.
REQ-002 Parameter DEPTH, default 2: entries per output queue; legal values 2 and 4.
REQ-003 Clock is clk, reset is reset_n; one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_sel  input  1  destination: 0 routes to port A, 1 routes to port B.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 in_ready  output  1  block accepts the word this cycle.
REQ-010 a_valid / b_valid  output  1  head word present on port A / port B.
REQ-011 a_data / b_data  output  WIDTH  head word of port A / port B queue.
REQ-012 a_ready / b_ready  input  1  downstream accepts the head word of port A / port B.

Function
REQ-013 Input transfer occurs when in_valid && in_ready on a rising edge; output transfer on port X occurs when X_valid && X_ready.
REQ-014 in_ready is combinational: it equals "queue selected by in_sel not full", with no dependence on a_ready or b_ready.
REQ-015 An accepted word is written to the tail of the selected queue; it is visible on X_valid/X_data on the cycle after acceptance (latency 1, no combinational bypass).
REQ-016 X_valid equals "queue X not empty"; X_data equals the queue head; X_data equals 0 when queue X is empty.
REQ-017 Each queue preserves FIFO order; words never cross between ports.
REQ-018 Occupancy counter per queue ranges 0..DEPTH: it increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
REQ-019 Full queue with pop in the same cycle: in_ready for that queue stays 0 that cycle, and the slot frees on the next cycle.
REQ-020 Empty queue with push: there is no same-cycle output, and X_valid rises on the next cycle.
REQ-021 Read/write pointers wrap modulo DEPTH.
REQ-022 A push to one queue and a pop from the other queue in the same cycle are independent and both complete.
REQ-023 Upstream protocol: in_sel and in_data are held stable while in_valid && !in_ready; the block does not check this.
REQ-024 Downstream stalls (X_ready held low) hold X_data stable and X_valid high.

Reset
REQ-025 Asserting reset_n low, at any time including mid-transfer, immediately empties both queues and zeroes all pointers and counters.
REQ-026 During and after reset, a_valid = b_valid = 0, a_data = b_data = 0, and in_ready = 1.
REQ-027 Words in flight at reset are discarded; the first accepted word after release appears on the following cycle.

Configuration
REQ-028 Macro STREAM_DEMUX2_STATS_EN: when defined, the module adds outputs a_count and b_count, each 32 bits.
REQ-029 With STREAM_DEMUX2_STATS_EN, a_count and b_count each increment on their port's output transfer, reset to 0, and wrap from 0xFFFFFFFF to 0.
REQ-030 Without STREAM_DEMUX2_STATS_EN, the ports and counters are absent and all other behaviour is identical.

Structure
REQ-031 Package demux_pkg holds: typedef port_id_t (1 bit; PORT_A = 0, PORT_B = 1), constant MAX_DEPTH = 4, and the stats counter width constant STAT_W = 32.
REQ-032 A single sub-module demux_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, head) is instantiated twice, once per port.
REQ-033 The top level contains only the select decode, the handshake logic, and the optional stats counters.

Verification
REQ-034 Reset sequence: release reset_n with no traffic -> a_valid = b_valid = 0, in_ready = 1, data outputs 0.
REQ-035 Routing: push 0x11 with sel = 0, then 0x22 with sel = 1, with both readies high -> 0x11 on A and 0x22 on B, each one cycle after its acceptance.
REQ-036 Backpressure: a_ready = 0, push 0xA0, 0xA1, 0xA2 to A -> in_ready drops after 2 accepts; B pushes are still accepted.
REQ-037 Order and wrap: with a_ready = 1, push 0xA0..0xA3 to A -> outputs appear in order, 0xA0..0xA3.
REQ-038 Full with simultaneous pop: with A full, assert a_ready and push -> push rejected that cycle and accepted the next cycle.
REQ-039 Reset mid-operation and stats: with two words queued, pulse reset_n -> both valids 0 immediately; with STREAM_DEMUX2_STATS_EN, counters read 0, then 3 A transfers -> a_count = 3.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the stream_demux2 block.
//   port_id_t : destination port encoding (PORT_A = 0, PORT_B = 1)
//   MAX_DEPTH : largest supported per-port queue depth
//   STAT_W    : width of the optional per-port transfer counters
package demux_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  localparam int unsigned MAX_DEPTH = 4;
  localparam int unsigned STAT_W    = 32;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO used as one output queue of stream_demux2.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write wdata at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   full, empty  : occupancy flags
//   head         : head entry, forced to 0 while empty
module demux_fifo
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = $clog2(MAX_DEPTH + 1);

  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("demux_fifo: DEPTH must be 2 or 4");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    // Simultaneous push and pop leaves occupancy unchanged.
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/stream_demux2.sv
// 1-to-2 stream demultiplexer with a small FIFO queue per output port.
// in_sel chooses the destination (0 -> A, 1 -> B); accepted words appear on
// the selected port one cycle later. in_ready depends only on the selected
// queue being not full.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   in_valid, in_sel, in_data   : upstream word and destination
//   in_ready                    : upstream word accepted this cycle
//   a_valid, a_data, a_ready    : port A stream
//   b_valid, b_data, b_ready    : port B stream
//   a_count, b_count            : output transfer counters, only when
//                                 STREAM_DEMUX2_STATS_EN is defined
module stream_demux2
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              a_valid,
  output logic [WIDTH-1:0]  a_data,
  input  logic              a_ready,
  output logic              b_valid,
  output logic [WIDTH-1:0]  b_data,
  input  logic              b_ready
`ifdef STREAM_DEMUX2_STATS_EN
  ,
  output logic [STAT_W-1:0] a_count,
  output logic [STAT_W-1:0] b_count
`endif
);

  port_id_t sel;
  logic     a_full, a_empty, b_full, b_empty;
  logic     a_push, b_push, a_pop, b_pop;

  assign sel = port_id_t'(in_sel);

  always_comb begin
    in_ready = 1'b0;
    a_push   = 1'b0;
    b_push   = 1'b0;
    unique case (sel)
      PORT_A: begin
        in_ready = !a_full;
        a_push   = in_valid && !a_full;
      end
      PORT_B: begin
        in_ready = !b_full;
        b_push   = in_valid && !b_full;
      end
      default: ;
    endcase
  end

  assign a_valid = !a_empty;
  assign b_valid = !b_empty;
  assign a_pop   = a_valid && a_ready;
  assign b_pop   = b_valid && b_ready;

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (a_push),
    .wdata   (in_data),
    .pop     (a_pop),
    .full    (a_full),
    .empty   (a_empty),
    .head    (a_data)
  );

  demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (b_push),
    .wdata   (in_data),
    .pop     (b_pop),
    .full    (b_full),
    .empty   (b_empty),
    .head    (b_data)
  );

`ifdef STREAM_DEMUX2_STATS_EN
  logic [STAT_W-1:0] a_count_q, b_count_q;

  // Counters wrap naturally at 2^STAT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      if (a_pop) a_count_q <= a_count_q + 1'b1;
      if (b_pop) b_count_q <= b_count_q + 1'b1;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_stream_demux2.sv
module tb_stream_demux2;
  import demux_pkg::*;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_sel, in_ready;
  logic [WIDTH-1:0] in_data;
  logic             a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_data, b_data;
`ifdef STREAM_DEMUX2_STATS_EN
  logic [STAT_W-1:0] a_count, b_count;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  stream_demux2 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready)
`ifdef STREAM_DEMUX2_STATS_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per port plus transfer counts.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int unsigned      ca, cb;

  function automatic logic [WIDTH-1:0] head_of(input logic [WIDTH-1:0] q[$]);
    return (q.size() > 0) ? q[0] : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      ca = 0;
      cb = 0;
    end else begin
      bit pa, pb, acc;
      // All decisions use the occupancy before this edge.
      pa  = (qa.size() > 0) && a_ready;
      pb  = (qb.size() > 0) && b_ready;
      acc = in_valid && ((in_sel ? qb.size() : qa.size()) < DEPTH);
      if (pa) begin void'(qa.pop_front()); ca++; end
      if (pb) begin void'(qb.pop_front()); cb++; end
      if (acc) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
  end

  // Compare process: outputs are stable in the low clock phase.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready", in_ready, ((in_sel ? qb.size() : qa.size()) < DEPTH));
      chk("m_a_valid", a_valid, qa.size() > 0);
      chk("m_b_valid", b_valid, qb.size() > 0);
      chk("m_a_data", a_data, head_of(qa));
      chk("m_b_data", b_data, head_of(qb));
`ifdef STREAM_DEMUX2_STATS_EN
      chk("m_a_count", a_count, ca);
      chk("m_b_count", b_count, cb);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    a_ready = 1'b0;
    b_ready = 1'b0;
    #1;
    cmp_en = 1'b1;

    // Reset state.
    repeat (2) cyc();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a_data", a_data, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel_a_valid", a_valid, 0);
    chk("rel_b_valid", b_valid, 0);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_b_data", b_data, 0);

    // Routing.
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b0, 64'h11);
    cyc();
    chk("route_a_valid", a_valid, 1);
    chk("route_a_data", a_data, 64'h11);
    drive(1'b1, 1'b1, 64'h22);
    cyc();
    chk("route_a_drained", a_valid, 0);
    chk("route_b_data", b_data, 64'h22);
    drive(1'b0, 1'b0, '0);
    cyc();
    chk("route_b_drained", b_valid, 0);

    // Backpressure on A; B still accepts.
    a_ready = 1'b0;
    drive(1'b1, 1'b0, 64'hA0);
    cyc();
    drive(1'b1, 1'b0, 64'hA1);
    cyc();
    drive(1'b1, 1'b0, 64'hA2);
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_a_head", a_data, 64'hA0);
    drive(1'b1, 1'b1, 64'hB0);
    #1;
    chk("bp_b_in_ready", in_ready, 1);
    cyc();
    chk("bp_b_data", b_data, 64'hB0);

    // Full queue with pop in the same cycle: push waits one cycle.
    a_ready = 1'b1;
    drive(1'b1, 1'b0, 64'hA2);
    #1;
    chk("fullpop_in_ready", in_ready, 0);
    cyc();
    chk("fullpop_next_ready", in_ready, 1);
    chk("order_a1", a_data, 64'hA1);
    cyc();
    chk("order_a2", a_data, 64'hA2);
    drive(1'b1, 1'b0, 64'hA3);
    cyc();
    chk("order_a3", a_data, 64'hA3);
    drive(1'b0, 1'b0, '0);
    cyc();
    chk("order_drained", a_valid, 0);

    // Reset mid-operation.
    a_ready = 1'b0;
    drive(1'b1, 1'b0, 64'hC0);
    cyc();
    drive(1'b1, 1'b0, 64'hC1);
    cyc();
    drive(1'b0, 1'b0, '0);
    #1;
    chk("mid_a_valid_pre", a_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_a_valid_rst", a_valid, 0);
    chk("mid_in_ready_rst", in_ready, 1);
    cyc();
    reset_n = 1'b1;
`ifdef STREAM_DEMUX2_STATS_EN
    chk("stats_zero", a_count, 0);
`endif
    a_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, WIDTH'(64'hD0 + i));
      cyc();
    end
    drive(1'b0, 1'b0, '0);
    cyc();
    chk("post_rst_drained", a_valid, 0);
`ifdef STREAM_DEMUX2_STATS_EN
    chk("stats_three", a_count, 3);
`endif

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !in_ready)) begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom), {$urandom, $urandom});
      end
      a_ready = 1'($urandom_range(0, 2) != 0);
      b_ready = 1'($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
      end
      cyc();
    end

    drive(1'b0, 1'b0, '0);
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
